spike_index_sink: RTL and testbench
===================================

# spike_index_sink

Parametrised successor network sink that converts one network output vector per handshake into a serial stream of `SNK_WIDTH`-bit words for the host link. Sits between the network core (`net_valid`/`net_ready`/`net_out`) and the output dispatcher (`snk_valid`/`snk_ready`/`snk`). It replaces single-cycle queue population with a registered capture followed by a one-word-per-cycle drain. It adds a selectable bitmap mode for dense outputs.

## Interface
- `NUM_OUT`, default 8: number of network outputs; must be ≥ 1.
- `MODE`, default 0: drain format. 0 = count then fired indices. 1 = count then raw bitmap chunks.
- `SNK_WIDTH`, derived as `$clog2(NUM_OUT+1)`: word width. It is a package constant, not overridable.
- `clk`, input, 1: clock.
- `arstn`, input, 1: reset, asynchronous, active-low.
- `net_valid`, input, 1: network output vector available.
- `net_ready`, output, 1: sink can capture a vector.
- `net_out`, input, `NUM_OUT`: fired outputs; bit i set means output i fired.
- `snk_ready`, input, 1: downstream accepts the current word.
- `snk_valid`, output, 1: `snk` holds a valid word.
- `snk`, output, `SNK_WIDTH`: current output word.

## Operation
- Three states: `IDLE`, `COUNT`, `DRAIN`.
- Reset values: state = `IDLE`, `net_ready` = 1, `snk_valid` = 0, `snk` = 0, captured vector = 0, count = 0, chunk pointer = 0.
- **IDLE**
  - `net_ready` = 1 and `snk_valid` = 0.
  - On `net_valid && net_ready`: register `net_out` into `vec`, register `popcount(net_out)` into `cnt`, set chunk pointer = 0, and go to `COUNT`.
- **COUNT**
  - `snk_valid` = 1 and `snk` = `cnt`.
  - On `snk_ready`:
    - MODE 0: go to `IDLE` if `cnt` == 0, else go to `DRAIN`.
    - MODE 1: always go to `DRAIN`.
- **DRAIN, MODE 0**
  - `snk` = index of the lowest set bit of `vec`, so indices are emitted in ascending order.
  - On `snk_ready`: clear that bit. If it was the last set bit, go to `IDLE`.
- **DRAIN, MODE 1**
  - `snk` = `vec[ptr*SNK_WIDTH +: SNK_WIDTH]`. Bits beyond `NUM_OUT` read as 0.
  - On `snk_ready`: increment `ptr`. After chunk `NUM_CHUNKS-1`, go to `IDLE`.
  - `NUM_CHUNKS` = ceil(`NUM_OUT`/`SNK_WIDTH`).
- Words per vector:
  - MODE 0: 1 + popcount.
  - MODE 1: 1 + `NUM_CHUNKS`, always, including for an all-zero vector.
- Width rules:
  - `cnt` is `SNK_WIDTH` bits and holds `NUM_OUT` without overflow.
  - `ptr` is `$clog2(NUM_CHUNKS+1)` bits.
  - An index is zero-extended to `SNK_WIDTH`.

## Timing
- Capture latency: a vector accepted at edge t produces `snk_valid` = 1 with the count word from t+1.
- Each drained word advances on the edge where `snk_valid && snk_ready`. With `snk_ready` held high, throughput is one word per cycle.
- `net_ready` is 1 only in `IDLE`. There is no overlap: the cycle after the last word's handshake is `IDLE`, so the minimum period is (words + 1) cycles per vector.
- Backpressure: while `snk_valid && !snk_ready`, `snk` and state hold stable. `snk_valid` never drops without a handshake.
- `net_out` is sampled only on the capture edge. Later changes have no effect until the next `IDLE`.
- Reset asserted mid-drain: everything returns to reset values immediately (asynchronously). The partial packet is discarded and no word is emitted after reset deasserts until a new capture.
- All outputs are decoded from registered state and `vec`. There is no combinational path from `snk_ready` or `net_valid` to any output except through a clock edge.

## Structure
- Package `sink_config` holds:
  - `SNK_WIDTH` and `NUM_CHUNKS` localparams, derived from `network_config::NET_NUM_OUT`;
  - a `sink_state_t` enum {`IDLE`, `COUNT`, `DRAIN`};
  - `MODE_INDEX` = 0 and `MODE_BITMAP` = 1 constants.
- Sub-module `lowest_set_index`, parametrised on width. It is a combinational priority encoder taking `vec` and outputting the index plus an `any` flag. The top level uses `any` after masking to detect the last bit.
- The popcount is an inline function in the package.

## Test plan
1. `NUM_OUT`=8, MODE 0, `net_out`=8'b1010_0100, `snk_ready`=1 → words 3, 2, 5, 7 on consecutive cycles; `net_ready` returns to 1 one cycle after the 7 is accepted.
2. MODE 0, `net_out`=0 → a single word 0, then `IDLE`. MODE 1, `net_out`=0 (`SNK_WIDTH`=4, `NUM_CHUNKS`=2) → words 0, 0, 0.
3. MODE 1, `NUM_OUT`=8, `net_out`=8'hB6 → words 5, 4'h6, 4'hB.
4. MODE 0, `net_out`=8'hFF, `snk_ready` toggling 1,0,0,1,… → words 8, 0..7 each held stable while not ready; no word is duplicated or lost.
5. MODE 0, `net_out` changes while draining 8'h81 → the stream remains 2, 0, 7; `net_ready` stays 0 until `IDLE`.
6. `arstn` pulsed low after the second word of 8'h0F → `snk_valid` = 0 immediately; the next capture of 8'h02 yields 1, 1 only.

Source files
------------

// File: rtl/network_config.sv
// Network-wide sizing shared by the core and its sinks.
package network_config;
  localparam int NET_NUM_OUT = 8;
endpackage

// File: rtl/sink_config.sv
// Sink word sizing, FSM encoding and the popcount helper for spike_index_sink.
package sink_config;
  localparam int SNK_WIDTH  = $clog2(network_config::NET_NUM_OUT + 1);
  localparam int NUM_CHUNKS = (network_config::NET_NUM_OUT + SNK_WIDTH - 1) / SNK_WIDTH;
  // Widest vector whose popcount still fits in a SNK_WIDTH word.
  localparam int POP_WIDTH  = (1 << SNK_WIDTH) - 1;

  localparam int MODE_INDEX  = 0;
  localparam int MODE_BITMAP = 1;

  typedef enum logic [1:0] {IDLE, COUNT, DRAIN} sink_state_t;

  function automatic logic [SNK_WIDTH-1:0] popcount(input logic [POP_WIDTH-1:0] v);
    logic [SNK_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < POP_WIDTH; i++) begin
      c = c + SNK_WIDTH'(v[i]);
    end
    return c;
  endfunction
endpackage

// File: rtl/lowest_set_index.sv
// Combinational priority encoder: index of the lowest set bit plus an any-set flag.
module lowest_set_index #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  // Scan downward so the lowest set bit wins the last assignment.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any = |vec;
endmodule

// File: rtl/spike_index_sink.sv
// Captures one network output vector and drains it as a count word followed by
// either fired indices (MODE 0) or raw bitmap chunks (MODE 1), one word per handshake.
module spike_index_sink
  import sink_config::*;
#(
  parameter int NUM_OUT = network_config::NET_NUM_OUT,
  parameter int MODE    = MODE_INDEX
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 net_valid,
  output logic                 net_ready,
  input  logic [NUM_OUT-1:0]   net_out,
  input  logic                 snk_ready,
  output logic                 snk_valid,
  output logic [SNK_WIDTH-1:0] snk
);
  localparam int CHUNKS = (NUM_OUT + SNK_WIDTH - 1) / SNK_WIDTH;
  localparam int PTR_W  = $clog2(CHUNKS + 1);
  localparam int PAD_W  = CHUNKS * SNK_WIDTH;

  sink_state_t          state_reg;
  logic [NUM_OUT-1:0]   vec_reg;
  logic [SNK_WIDTH-1:0] cnt_reg;
  logic [PTR_W-1:0]     ptr_reg;
  logic [SNK_WIDTH-1:0] snk_reg;
  logic                 snk_valid_reg;
  logic                 net_ready_reg;

  logic [NUM_OUT-1:0]   cur_bit;
  logic [NUM_OUT-1:0]   vec_cleared;
  logic [NUM_OUT-1:0]   enc_in;
  logic [SNK_WIDTH-1:0] enc_idx;
  logic                 enc_any;
  logic [PTR_W-1:0]     ptr_sel;
  logic [PAD_W-1:0]     vec_pad;
  logic [SNK_WIDTH-1:0] chunk_next;
  logic [SNK_WIDTH-1:0] pop;

  // In DRAIN the current index is still set in vec_reg; the encoder looks
  // ahead at the vector with it cleared so the next word can be registered.
  always_comb begin
    cur_bit     = NUM_OUT'(1) << snk_reg;
    vec_cleared = vec_reg & ~cur_bit;
    enc_in      = (state_reg == DRAIN) ? vec_cleared : vec_reg;
    ptr_sel     = (state_reg == COUNT) ? '0 : ptr_reg + PTR_W'(1);
    vec_pad     = PAD_W'(vec_reg);
    chunk_next  = SNK_WIDTH'(vec_pad >> (int'(ptr_sel) * SNK_WIDTH));
    pop         = popcount(POP_WIDTH'(net_out));
  end

  lowest_set_index #(
    .WIDTH (NUM_OUT),
    .IDX_W (SNK_WIDTH)
  ) u_lowest_set_index (
    .vec (enc_in),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_reg     <= IDLE;
      vec_reg       <= '0;
      cnt_reg       <= '0;
      ptr_reg       <= '0;
      snk_reg       <= '0;
      snk_valid_reg <= 1'b0;
      net_ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (net_valid) begin
            vec_reg       <= net_out;
            cnt_reg       <= pop;
            ptr_reg       <= '0;
            snk_reg       <= pop;
            snk_valid_reg <= 1'b1;
            net_ready_reg <= 1'b0;
            state_reg     <= COUNT;
          end
        end
        COUNT: begin
          if (snk_ready) begin
            if (MODE == MODE_BITMAP) begin
              snk_reg   <= chunk_next;
              state_reg <= DRAIN;
            end else if (cnt_reg == '0) begin
              snk_reg       <= '0;
              snk_valid_reg <= 1'b0;
              net_ready_reg <= 1'b1;
              state_reg     <= IDLE;
            end else begin
              snk_reg   <= enc_idx;
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (snk_ready) begin
            if (MODE == MODE_BITMAP) begin
              if (ptr_reg == PTR_W'(CHUNKS - 1)) begin
                snk_reg       <= '0;
                snk_valid_reg <= 1'b0;
                net_ready_reg <= 1'b1;
                state_reg     <= IDLE;
              end else begin
                ptr_reg <= ptr_reg + PTR_W'(1);
                snk_reg <= chunk_next;
              end
            end else begin
              vec_reg <= vec_cleared;
              if (!enc_any) begin
                snk_reg       <= '0;
                snk_valid_reg <= 1'b0;
                net_ready_reg <= 1'b1;
                state_reg     <= IDLE;
              end else begin
                snk_reg <= enc_idx;
              end
            end
          end
        end
        default: begin
          snk_valid_reg <= 1'b0;
          net_ready_reg <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign net_ready = net_ready_reg;
  assign snk_valid = snk_valid_reg;
  assign snk       = snk_reg;
endmodule

// File: tb/tb_spike_index_sink.sv
// Drives an index-mode and a bitmap-mode sink with table, hand-written and random vectors.
module tb_spike_index_sink;
  logic       clk;
  logic       arstn;
  logic       nv [2];
  logic       nr [2];
  logic [7:0] no [2];
  logic       sr [2];
  logic       sv [2];
  logic [3:0] s  [2];

  int tests;
  int fails;

  typedef struct {
    int         mode;
    logic [7:0] vec;
    int         pat;
    int         n;
    int         w [9];
  } vec_t;

  vec_t vt [9];

  spike_index_sink #(.NUM_OUT(8), .MODE(0)) u_idx (
    .clk       (clk),
    .arstn     (arstn),
    .net_valid (nv[0]),
    .net_ready (nr[0]),
    .net_out   (no[0]),
    .snk_ready (sr[0]),
    .snk_valid (sv[0]),
    .snk       (s[0])
  );

  spike_index_sink #(.NUM_OUT(8), .MODE(1)) u_bmp (
    .clk       (clk),
    .arstn     (arstn),
    .net_valid (nv[1]),
    .net_ready (nr[1]),
    .net_out   (no[1]),
    .snk_ready (sr[1]),
    .snk_valid (sv[1]),
    .snk       (s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference word list built directly from the packet format rules.
  task automatic model(input int m, input logic [7:0] v, output int n, output int w [9]);
    int vi;
    int c;
    vi = int'(v);
    c  = 0;
    for (int i = 0; i < 8; i++) c += (vi >> i) & 1;
    for (int i = 0; i < 9; i++) w[i] = 0;
    n = 0;
    w[n++] = c;
    if (m == 0) begin
      for (int i = 0; i < 8; i++) if (((vi >> i) & 1) == 1) w[n++] = i;
    end else begin
      for (int ch = 0; ch < 2; ch++) w[n++] = (vi >> (4 * ch)) & 15;
    end
  endtask

  // pat: 0 = always ready, 1 = random ready, 2 = ready one cycle in three.
  task automatic run_pkt(input int m, input logic [7:0] v, input int pat,
                         input int n, input int w [9], input string name);
    int   k;
    int   cyc;
    logic r;
    @(negedge clk);
    chk({name, " idle_ready"}, int'(nr[m]), 1);
    chk({name, " idle_valid"}, int'(sv[m]), 0);
    nv[m] = 1'b1;
    no[m] = v;
    @(negedge clk);
    nv[m] = 1'b0;
    no[m] = 8'($urandom);
    k   = 0;
    cyc = 0;
    while (k < n && cyc < 200) begin
      case (pat)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = (cyc % 3 == 0);
      endcase
      sr[m] = r;
      chk($sformatf("%s valid[%0d]", name, k), int'(sv[m]), 1);
      chk($sformatf("%s busy_ready[%0d]", name, k), int'(nr[m]), 0);
      chk($sformatf("%s word[%0d]", name, k), int'(s[m]), w[k]);
      if (r && sv[m]) k++;
      cyc++;
      @(negedge clk);
    end
    sr[m] = 1'b0;
    tests++;
    if (k < n) begin
      fails++;
      $display("FAIL %s timeout: got %0d words, expected %0d", name, k, n);
    end
    chk({name, " end_valid"}, int'(sv[m]), 0);
    chk({name, " end_ready"}, int'(nr[m]), 1);
    $display("[TB] pkt %s mode=%0d vec=%02h pat=%0d words=%0d", name, m, v, pat, n);
  endtask

  initial begin
    int   n;
    int   w [9];
    int   m;
    int   pat;
    logic [7:0] v;

    tests = 0;
    fails = 0;
    arstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      nv[i] = 1'b0;
      no[i] = 8'h00;
      sr[i] = 1'b0;
    end

    vt[0] = '{0, 8'hA4, 0, 4, '{3, 2, 5, 7, 0, 0, 0, 0, 0}};
    vt[1] = '{0, 8'h00, 0, 1, '{0, 0, 0, 0, 0, 0, 0, 0, 0}};
    vt[2] = '{1, 8'h00, 0, 3, '{0, 0, 0, 0, 0, 0, 0, 0, 0}};
    vt[3] = '{1, 8'hB6, 0, 3, '{5, 6, 11, 0, 0, 0, 0, 0, 0}};
    vt[4] = '{0, 8'hFF, 2, 9, '{8, 0, 1, 2, 3, 4, 5, 6, 7}};
    vt[5] = '{0, 8'h81, 0, 3, '{2, 0, 7, 0, 0, 0, 0, 0, 0}};
    vt[6] = '{1, 8'hFF, 2, 3, '{8, 15, 15, 0, 0, 0, 0, 0, 0}};
    vt[7] = '{0, 8'h80, 1, 2, '{1, 7, 0, 0, 0, 0, 0, 0, 0}};
    vt[8] = '{0, 8'h01, 0, 2, '{1, 0, 0, 0, 0, 0, 0, 0, 0}};

    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_valid%0d", i), int'(sv[i]), 0);
      chk($sformatf("rst_ready%0d", i), int'(nr[i]), 1);
      chk($sformatf("rst_snk%0d", i), int'(s[i]), 0);
    end
    arstn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_pkt(vt[i].mode, vt[i].vec, vt[i].pat, vt[i].n, vt[i].w, $sformatf("tab%0d", i));
    end

    // Asynchronous reset in the middle of a packet discards it.
    @(negedge clk);
    nv[0] = 1'b1;
    no[0] = 8'h0F;
    @(negedge clk);
    nv[0] = 1'b0;
    sr[0] = 1'b1;
    chk("rstmid word0", int'(s[0]), 4);
    @(negedge clk);
    chk("rstmid word1", int'(s[0]), 0);
    @(negedge clk);
    chk("rstmid word2", int'(s[0]), 1);
    sr[0] = 1'b0;
    arstn = 1'b0;
    #1;
    chk("rstmid valid", int'(sv[0]), 0);
    chk("rstmid ready", int'(nr[0]), 1);
    @(negedge clk);
    arstn = 1'b1;
    sr[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rstmid quiet%0d", i), int'(sv[0]), 0);
    end
    sr[0] = 1'b0;
    $display("[TB] pkt rstmid mode=0 vec=0f aborted after 2 words");
    model(0, 8'h02, n, w);
    run_pkt(0, 8'h02, 0, n, w, "postrst");

    for (int i = 0; i < 30; i++) begin
      m   = int'($urandom_range(0, 1));
      v   = 8'($urandom);
      pat = int'($urandom_range(0, 2));
      model(m, v, n, w);
      run_pkt(m, v, pat, n, w, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
